// File: rtl/fetch_decode_pipe.sv
// fetch_decode_pipe: MIPS fetch stage (PC select) plus IF/ID register and stall/flush counters
// Ports: clk/reset (sync, active-high); StallF/StallD from hazard unit;
//   PCSrcD/PCBranchD and JumpD/PCJumpD redirect requests from Decode;
//   InstrF from instruction memory for PCF; PCF fetch address;
//   InstrD/PCPlus4D/ValidD IF/ID contents; RsD/RtD/RdD register fields of InstrD;
//   StallCount/FlushCount saturating performance counters.
module fetch_decode_pipe #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          CNT_W    = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             StallF,
  input  logic             StallD,
  input  logic             PCSrcD,
  input  logic [31:0]      PCBranchD,
  input  logic             JumpD,
  input  logic [31:0]      PCJumpD,
  input  logic [31:0]      InstrF,
  output logic [31:0]      PCF,
  output logic [31:0]      InstrD,
  output logic [31:0]      PCPlus4D,
  output logic             ValidD,
  output logic [4:0]       RsD,
  output logic [4:0]       RtD,
  output logic [4:0]       RdD,
  output logic [CNT_W-1:0] StallCount,
  output logic [CNT_W-1:0] FlushCount
);
  logic [31:0]      pc_q, pc_d, instr_q, instr_d, p4_q, p4_d, pc_plus4;
  logic             valid_q, valid_d, redirect;
  logic [CNT_W-1:0] stall_q, stall_d, flush_q, flush_d;
  // A stalled Decode has stale branch operands, so its redirect request is ignored.
  assign redirect = (PCSrcD | JumpD) & ~StallD;
  assign pc_plus4 = pc_q + 32'd4;
  always_comb begin
    pc_d    = StallF ? pc_q
            : (redirect & JumpD) ? {PCJumpD[31:2], 2'b00}
            : (redirect & PCSrcD) ? {PCBranchD[31:2], 2'b00}
            : pc_plus4;
    instr_d = StallD ? instr_q : redirect ? 32'd0 : InstrF;
    p4_d    = StallD ? p4_q : redirect ? 32'd0 : pc_plus4;
    valid_d = StallD ? valid_q : ~redirect;
    stall_d = (StallF && !(&stall_q)) ? stall_q + CNT_W'(1) : stall_q;
    flush_d = (redirect && !(&flush_q)) ? flush_q + CNT_W'(1) : flush_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q    <= {RESET_PC[31:2], 2'b00};
      instr_q <= '0;
      p4_q    <= '0;
      valid_q <= 1'b0;
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      pc_q    <= pc_d;
      instr_q <= instr_d;
      p4_q    <= p4_d;
      valid_q <= valid_d;
      stall_q <= stall_d;
      flush_q <= flush_d;
    end
  end
  assign PCF        = pc_q;
  assign InstrD     = instr_q;
  assign PCPlus4D   = p4_q;
  assign ValidD     = valid_q;
  assign RsD        = instr_q[25:21];
  assign RtD        = instr_q[20:16];
  assign RdD        = instr_q[15:11];
  assign StallCount = stall_q;
  assign FlushCount = flush_q;
endmodule

// File: tb/tb_fetch_decode_pipe.sv
// tb_fetch_decode_pipe: table-driven and scoreboard checks of the fetch/IF-ID pipe
module tb_fetch_decode_pipe;
  logic        clk = 1'b0;
  logic        reset, StallF, StallD, PCSrcD, JumpD;
  logic [31:0] PCBranchD, PCJumpD, InstrF, PCF, InstrD, PCPlus4D;
  logic        ValidD;
  logic [4:0]  RsD, RtD, RdD;
  logic [15:0] StallCount, FlushCount;

  typedef struct {
    logic        rst, sf, sd, br;
    logic [31:0] bt;
    logic        jp;
    logic [31:0] jt, pcf;
    logic        v;
  } vec_t;

  typedef struct {
    logic [31:0] instr, p4;
    logic [15:0] sc, fc;
  } exp_t;

  vec_t tbl[$];
  exp_t sb[$];
  int   n_cmp = 0, n_err = 0;

  logic [31:0] m_pc, m_instr, m_p4;
  logic        m_v;
  logic [15:0] m_sc, m_fc;

  always #5 clk = ~clk;

  function automatic logic [31:0] imem(input logic [31:0] a);
    return a ^ 32'h02A4_5800;
  endfunction

  assign InstrF = imem(PCF);

  fetch_decode_pipe dut (
    .clk(clk), .reset(reset), .StallF(StallF), .StallD(StallD),
    .PCSrcD(PCSrcD), .PCBranchD(PCBranchD), .JumpD(JumpD), .PCJumpD(PCJumpD),
    .InstrF(InstrF), .PCF(PCF), .InstrD(InstrD), .PCPlus4D(PCPlus4D),
    .ValidD(ValidD), .RsD(RsD), .RtD(RtD), .RdD(RdD),
    .StallCount(StallCount), .FlushCount(FlushCount)
  );

  task automatic add(input logic rst, sf, sd, br, input logic [31:0] bt,
                     input logic jp, input logic [31:0] jt, pcf, input logic v);
    vec_t r;
    r.rst = rst; r.sf = sf; r.sd = sd; r.br = br; r.bt = bt;
    r.jp = jp; r.jt = jt; r.pcf = pcf; r.v = v;
    tbl.push_back(r);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: advances one clock using the inputs currently driven.
  task automatic model_step();
    logic rd;
    rd = (PCSrcD | JumpD) & ~StallD;
    if (reset) begin
      m_pc = 32'h0; m_instr = 32'h0; m_p4 = 32'h0; m_v = 1'b0; m_sc = 16'h0; m_fc = 16'h0;
    end else begin
      if (!StallD) begin
        m_instr = rd ? 32'h0 : imem(m_pc);
        m_p4    = rd ? 32'h0 : m_pc + 32'd4;
        m_v     = !rd;
      end
      if (StallF && m_sc != 16'hFFFF) m_sc = m_sc + 16'd1;
      if (rd && m_fc != 16'hFFFF) m_fc = m_fc + 16'd1;
      if (!StallF) m_pc = (rd & JumpD) ? (PCJumpD & ~32'h3)
                        : (rd & PCSrcD) ? (PCBranchD & ~32'h3) : m_pc + 32'd4;
    end
  endtask

  initial begin
    exp_t e;
    m_pc = 0; m_instr = 0; m_p4 = 0; m_v = 0; m_sc = 0; m_fc = 0;
    reset = 1'b1; StallF = 1'b0; StallD = 1'b0; PCSrcD = 1'b0; JumpD = 1'b0;
    PCBranchD = 32'h0; PCJumpD = 32'h0;
    //  rst   sf    sd    br    bt            jp    jt            pcf           v
    add(1'b1, 1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0,        32'h0,        1'b0);
    add(1'b1, 1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0,        32'h0,        1'b0);
    add(1'b1, 1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0,        32'h0,        1'b0);
    add(1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0,        32'h4,        1'b1);
    add(1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0,        32'h8,        1'b1);
    add(1'b0, 1'b1, 1'b1, 1'b0, 32'h0,        1'b0, 32'h0,        32'h8,        1'b1);
    add(1'b0, 1'b1, 1'b1, 1'b0, 32'h0,        1'b0, 32'h0,        32'h8,        1'b1);
    add(1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0,        32'hC,        1'b1);
    add(1'b0, 1'b0, 1'b0, 1'b1, 32'h40,       1'b0, 32'h0,        32'h40,       1'b0);
    add(1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0,        32'h44,       1'b1);
    add(1'b0, 1'b1, 1'b1, 1'b1, 32'h80,       1'b0, 32'h0,        32'h44,       1'b1);
    add(1'b0, 1'b0, 1'b0, 1'b1, 32'h80,       1'b0, 32'h0,        32'h80,       1'b0);
    add(1'b0, 1'b0, 1'b0, 1'b1, 32'h200,      1'b1, 32'h100,      32'h100,      1'b0);
    add(1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0,        32'h104,      1'b1);
    add(1'b0, 1'b0, 1'b0, 1'b1, 32'h43,       1'b0, 32'h0,        32'h40,       1'b0);
    add(1'b0, 1'b1, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0,        32'h40,       1'b1);
    add(1'b0, 1'b1, 1'b0, 1'b1, 32'h10,       1'b0, 32'h0,        32'h40,       1'b0);
    add(1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 1'b0);
    add(1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0,        32'h0,        1'b1);
    add(1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0,        32'h4,        1'b1);
    add(1'b0, 1'b1, 1'b1, 1'b0, 32'h0,        1'b0, 32'h0,        32'h4,        1'b1);
    add(1'b0, 1'b1, 1'b1, 1'b1, 32'h80,       1'b0, 32'h0,        32'h0,        1'b0);
    tbl[21].rst = 1'b1;
    foreach (tbl[i]) begin
      reset = tbl[i].rst; StallF = tbl[i].sf; StallD = tbl[i].sd;
      PCSrcD = tbl[i].br; PCBranchD = tbl[i].bt; JumpD = tbl[i].jp; PCJumpD = tbl[i].jt;
      model_step();
      e.instr = m_instr; e.p4 = m_p4; e.sc = m_sc; e.fc = m_fc;
      sb.push_back(e);
      @(posedge clk);
      #1;
      if (sb.size() == 0) begin
        n_cmp++; n_err++;
        $display("FAIL row%0d scoreboard: got empty queue expected one entry", i);
      end else begin
        e = sb.pop_front();
        chk($sformatf("row%0d PCF", i), PCF, tbl[i].pcf);
        chk($sformatf("row%0d ValidD", i), 32'(ValidD), 32'(tbl[i].v));
        chk($sformatf("row%0d InstrD", i), InstrD, e.instr);
        chk($sformatf("row%0d PCPlus4D", i), PCPlus4D, e.p4);
        chk($sformatf("row%0d RsRtRd", i), 32'({RsD, RtD, RdD}),
            32'({e.instr[25:21], e.instr[20:16], e.instr[15:11]}));
        chk($sformatf("row%0d StallCount", i), 32'(StallCount), 32'(e.sc));
        chk($sformatf("row%0d FlushCount", i), 32'(FlushCount), 32'(e.fc));
      end
    end
    // Long stall from reset: counter must climb to all-ones and stop there.
    reset = 1'b0; StallF = 1'b1; StallD = 1'b1; PCSrcD = 1'b0; JumpD = 1'b0;
    repeat (65534) @(posedge clk);
    #1;
    chk("sat StallCount pre", 32'(StallCount), 32'h0000_FFFE);
    repeat (7) @(posedge clk);
    #1;
    chk("sat StallCount", 32'(StallCount), 32'h0000_FFFF);
    chk("sat FlushCount", 32'(FlushCount), 32'h0);
    chk("sat PCF", PCF, 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end
endmodule
